uram_stream_reader: RTL
=======================

// Module: uram_stream_reader
// PURPOSE
//  Read-side master for the rf_buffer UltraRAM port: sweeps a programmed address range,
//  issues no-write reads into a fixed-latency (NBPIPE+2) pipelined URAM port, and returns the words as a
//  valid/ready stream with last. Credit-limited: the local FIFO never overflows, whatever the m_tready backpressure.
//  Sits between the URAM port and the debug readout/DMA stream.
// PARAMETERS
//  AWIDTH     12  memory address width; range wraps modulo 2^AWIDTH
//  NUM_COL    9   byte-write columns of the memory port (write enables driven all-zero)
//  DWIDTH     72  data width
//  NBPIPE     3   memory output pipeline stages; read latency RD_LAT = NBPIPE+2
//  FIFO_DEPTH 8   return FIFO entries; must be >= RD_LAT (elaboration error otherwise)
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst        in   1          reset, asynchronous, active-high
//  start      in   1          1-cycle pulse; sampled only in IDLE (ignored otherwise)
//  start_addr in   AWIDTH     first address, latched on start
//  length     in   AWIDTH+1   word count, 0..2^AWIDTH, latched on start
//  abort      in   1          stop sweep, discard outstanding data
//  busy       out  1          high in ISSUE/DRAIN
//  done       out  1          1-cycle pulse on entry to IDLE from DRAIN
//  aborted    out  1          sticky: last op ended by abort; cleared on next accepted start
//  mem_en     out  1          memory enable (one read per high cycle)
//  mem_we     out  NUM_COL    write enables, constant 0
//  mem_regce  out  1          output register enable, constant 1
//  mem_rst    out  1          memory output reset, constant 0
//  mem_addr   out  AWIDTH     read address
//  mem_dout   in   DWIDTH     memory read data, valid RD_LAT cycles after mem_en
//  m_tdata    out  DWIDTH     stream data
//  m_tvalid   out  1          stream valid
//  m_tready   in   1          stream ready
//  m_tlast    out  1          final word of the sweep
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, aborted, mem_en, m_tvalid, m_tlast = 0; mem_addr = 0; FIFO empty;
//   in-flight shift register cleared. The reset is asynchronous, so mid-sweep it immediately stops issue.
//   Returning memory data is dropped because the in-flight register is clear.
//  Latency tracking: shift register vld_sr[RD_LAT-1:0] <= {vld_sr, mem_en}. The word at mem_dout is pushed
//   into the FIFO on the cycle vld_sr[RD_LAT-1]=1. inflight = popcount(vld_sr).
//  Credit: mem_en=1 only if state==ISSUE && remaining!=0 && (fifo_count + inflight) < FIFO_DEPTH.
//   fifo_count is taken before this cycle's pop, so the FIFO can never overflow.
//  Addressing: mem_addr = start_addr + issued (mod 2^AWIDTH); wraps from 2^AWIDTH-1 to 0 without error.
//  FSM:
//   IDLE  -start & length!=0-> ISSUE (latch start_addr/length; clear aborted).
//         start & length==0 -> stays IDLE, done pulses the next cycle, no stream beat.
//   ISSUE -last read issued (remaining becomes 0)-> DRAIN.
//         abort -> DRAIN with discard=1 (abort wins over a same-cycle final issue; that read is not issued).
//   DRAIN -> IDLE when inflight==0 && FIFO empty && no pop pending; done pulses on that transition.
//  Discard (abort): FIFO flushed in the abort cycle, and later returns are not pushed.
//   m_tvalid is forced 0 from the cycle after abort. aborted=1 on exit. No m_tlast beat occurs.
//   An abort in IDLE/DRAIN-without-discard: during DRAIN, abort also sets discard. In IDLE it is ignored.
//  Stream: m_tvalid = FIFO non-empty (and !discard). Beat on m_tvalid & m_tready.
//   While m_tvalid is high and m_tready is low, m_tdata, m_tlast and m_tvalid must hold stable.
//   m_tlast=1 only on the beat carrying word index length-1.
//   Push and pop in the same cycle leave fifo_count unchanged.
//  Throughput: with m_tready held 1 and FIFO_DEPTH >= RD_LAT, one read is issued per cycle.
//   First m_tvalid comes RD_LAT+1 cycles after start (FIFO registered output).
// TESTING
//  T1 length=4,start_addr=0x010,m_tready=1 -> mem_addr 0x010..0x013 consecutive; 4 beats, tlast on 4th, done 1 pulse
//  T2 start_addr=0xFFE,length=4 -> mem_addr FFE,FFF,000,001; data order preserved
//  T3 length=32, m_tready=0 for 50 cycles then 1 -> mem_en stops after FIFO_DEPTH issues; no loss/dup; 32 beats
//  T4 length=16, abort at 6th issue -> no further mem_en, m_tvalid 0 next cycle, done pulse, aborted=1, no tlast
//  T5 length=0 -> no mem_en, no beat, done pulses once; start while busy ignored
//  T6 rst asserted mid-sweep (async, between edges) -> outputs zero immediately; next sweep data exact

Source files
------------

// File: rtl/uram_stream_reader.sv
// ---------------------------------------------------------------------------
// uram_stream_reader
//
// Read-side master for the rf_buffer UltraRAM port. A start pulse latches a
// base address and a word count. The block then sweeps the range with
// no-write reads into a fixed-latency (NBPIPE+2) pipelined URAM port and
// returns the words as a valid/ready stream with last. Reads are
// credit-limited, so the local return FIFO can never overflow, whatever the
// m_tready backpressure.
//
// Ports
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   start           1-cycle pulse, honoured only while idle
//   start_addr      first address of the sweep (wraps modulo 2^AWIDTH)
//   length          word count 0..2^AWIDTH
//   abort           stop the sweep and discard outstanding data
//   busy            sweep in progress (issuing or draining)
//   done            1-cycle pulse when the block returns to idle
//   aborted         sticky: last operation ended by abort
//   mem_*           URAM port (read-only use: we=0, regce=1, rst=0)
//   mem_dout        read data, valid RD_LAT cycles after mem_en
//   m_t*            output stream
//
// Stream handshake: a beat transfers on any rising edge where m_tvalid and
// m_tready are both high. Once m_tvalid is high it stays high, and m_tdata
// and m_tlast stay stable, until the beat is taken. The only exception is an
// abort, which withdraws the stream from the following cycle onwards.
// ---------------------------------------------------------------------------
module uram_stream_reader #(
    parameter int AWIDTH     = 12,
    parameter int NUM_COL    = 9,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AWIDTH-1:0]  start_addr,
    input  logic [AWIDTH:0]    length,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               mem_en,
    output logic [NUM_COL-1:0] mem_we,
    output logic               mem_regce,
    output logic               mem_rst,
    output logic [AWIDTH-1:0]  mem_addr,
    input  logic [DWIDTH-1:0]  mem_dout,
    output logic [DWIDTH-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast
);

    localparam int RD_LAT = NBPIPE + 2;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam int LW     = AWIDTH + 1;

    // The credit scheme relies on the FIFO being able to absorb every read
    // that can be in flight at once.
    if (FIFO_DEPTH < RD_LAT) begin : g_depth_check
        $error("uram_stream_reader: FIFO_DEPTH must be >= NBPIPE+2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Control registers
    state_t              state_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [LW-1:0]       remaining_q;
    logic [LW-1:0]       length_q;
    logic [LW-1:0]       push_idx_q;
    logic                discard_q;
    logic                done_q;
    logic                aborted_q;
    logic [RD_LAT-1:0]   vld_sr_q;

    // Return FIFO
    logic [DWIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;

    logic [CW-1:0]       inflight;
    logic [CW-1:0]       credit_used;
    logic                issue;
    logic                flush;
    logic                push;
    logic                push_last;
    logic                pop;
    logic                drain_done;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vld_sr_q[i]);
        end
    end

    // Credit counts the FIFO occupancy before this cycle's pop, so a read is
    // only issued when a slot is guaranteed for it on return.
    assign credit_used = fifo_cnt_q + inflight;

    // Abort wins over a same-cycle issue.
    assign issue = (state_q == S_ISSUE) && (remaining_q != '0) &&
                   (credit_used < CW'(FIFO_DEPTH)) && !abort;

    assign flush      = abort && (state_q != S_IDLE);
    assign push       = vld_sr_q[RD_LAT-1] && !discard_q && !flush;
    assign push_last  = (push_idx_q == (length_q - LW'(1)));
    assign m_tvalid   = (fifo_cnt_q != '0) && !discard_q;
    assign pop        = m_tvalid && m_tready;
    assign drain_done = (vld_sr_q == '0) && (fifo_cnt_q == '0);

    // FIFO pointer / occupancy next state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
            else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_dout;
            fifo_last_q[wr_ptr_q] <= push_last;
        end
    end

    // Sweep FSM and its bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            length_q    <= '0;
            push_idx_q  <= '0;
            discard_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            vld_sr_q    <= '0;
        end else begin
            vld_sr_q <= {vld_sr_q[RD_LAT-2:0], issue};
            done_q   <= 1'b0;
            if (push) push_idx_q <= push_idx_q + LW'(1);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        aborted_q  <= 1'b0;
                        discard_q  <= 1'b0;
                        push_idx_q <= '0;
                        if (length != '0) begin
                            state_q     <= S_ISSUE;
                            addr_q      <= start_addr;
                            remaining_q <= length;
                            length_q    <= length;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        state_q   <= S_DRAIN;
                        discard_q <= 1'b1;
                    end else if (issue) begin
                        addr_q      <= addr_q + AWIDTH'(1);
                        remaining_q <= remaining_q - LW'(1);
                        if (remaining_q == LW'(1)) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        discard_q <= 1'b1;
                    end else if (drain_done) begin
                        state_q   <= S_IDLE;
                        done_q    <= 1'b1;
                        aborted_q <= discard_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign mem_en    = issue;
    assign mem_addr  = addr_q;
    assign mem_we    = '0;
    assign mem_regce = 1'b1;
    assign mem_rst   = 1'b0;
    assign m_tdata   = fifo_data_q[rd_ptr_q];
    assign m_tlast   = m_tvalid && fifo_last_q[rd_ptr_q];

endmodule
